// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and defaults for the PC sequencing controller.
// Holds state encodings, address width and stall/interrupt defaults.
package pc_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int MCNT_W = 4;
    localparam int HCNT_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        PCC_RUN = 1'b0,
        PCC_INT = 1'b1
    } pcc_state_t;

    localparam addr_t INT_VECTOR_DEF = 16'h0008;
    localparam int    MEM_STALL_DEF  = 2;

endpackage

// File: rtl/pcc_stall_cnt.sv
// pcc_stall_cnt: memory-stall down-counter plus saturating held-cycle count.
// Ports: clk, rst (async active-low), mem_req, load_use -> hold, hold_cnt.
module pcc_stall_cnt
    import pc_ctrl_pkg::*;
#(
    parameter int MEM_STALL_CYCLES = MEM_STALL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              load_use,
    output logic              hold,
    output logic [HCNT_W-1:0] hold_cnt
);

    localparam logic [MCNT_W-1:0] RELOAD = MCNT_W'(MEM_STALL_CYCLES);
    localparam logic [HCNT_W-1:0] HMAX   = '1;

    logic [MCNT_W-1:0] mcnt;

    // OR-merge: overlapping sources never extend the stall
    assign hold = load_use | mem_req | (mcnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt     <= '0;
            hold_cnt <= '0;
        end else begin
            if (mem_req)
                mcnt <= RELOAD;
            else if (mcnt != '0)
                mcnt <= mcnt - 1'b1;

            if (hold && hold_cnt != HMAX)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: merges fetch stalls into hold, arbitrates PC redirects and
// buffers redirects that arrive while held. Ports: stall/redirect requests
// in; hold, set_pc/set_pc_addr, flush, int_ack, epc, in_int, hold_cnt out.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter addr_t INT_VECTOR       = INT_VECTOR_DEF,
    parameter int    MEM_STALL_CYCLES = MEM_STALL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              load_use,
    input  logic              mem_req,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              int_req,
    input  logic              eret_req,
    output logic              hold,
    output logic              set_pc,
    output logic [ADDR_W-1:0] set_pc_addr,
    output logic              flush,
    output logic              int_ack,
    output logic [ADDR_W-1:0] epc,
    output logic              in_int,
    output logic [HCNT_W-1:0] hold_cnt
);

    pcc_state_t  state;
    logic        pend_v;
    addr_t       pend_addr;

    logic eret_ok;
    logic sel_pend;
    logic sel_eret;
    logic sel_br;
    logic sel_int;

    pcc_stall_cnt #(
        .MEM_STALL_CYCLES(MEM_STALL_CYCLES)
    ) u_stall (
        .clk     (clk),
        .rst     (rst),
        .mem_req (mem_req),
        .load_use(load_use),
        .hold    (hold),
        .hold_cnt(hold_cnt)
    );

    assign in_int  = (state == PCC_INT);
    assign eret_ok = eret_req & in_int;

    // One-hot issue selects, highest priority first
    assign sel_pend = !hold & pend_v;
    assign sel_eret = !hold & !pend_v & eret_ok;
    assign sel_br   = !hold & !pend_v & !eret_ok & branch_req;
    assign sel_int  = !hold & !pend_v & !branch_req
                    & int_req & !in_int;

    always_comb begin
        set_pc      = 1'b0;
        set_pc_addr = '0;
        flush       = 1'b0;
        int_ack     = 1'b0;
        unique case (1'b1)
            sel_pend: begin
                set_pc      = 1'b1;
                set_pc_addr = pend_addr;
                flush       = 1'b1;
            end
            sel_eret: begin
                set_pc      = 1'b1;
                set_pc_addr = epc;
                flush       = 1'b1;
            end
            sel_br: begin
                set_pc      = 1'b1;
                set_pc_addr = branch_addr;
                flush       = 1'b1;
            end
            sel_int: begin
                set_pc      = 1'b1;
                set_pc_addr = INT_VECTOR;
                flush       = 1'b1;
                int_ack     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PCC_RUN;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            epc       <= '0;
        end else begin
            // Held redirects park here; the newest one wins
            if (hold && (eret_ok || branch_req)) begin
                pend_v    <= 1'b1;
                pend_addr <= eret_ok ? epc : branch_addr;
            end else if (sel_pend) begin
                pend_v    <= 1'b0;
            end

            unique case (state)
                PCC_RUN: begin
                    if (sel_int) begin
                        state <= PCC_INT;
                        epc   <= pc;
                    end
                end
                PCC_INT: begin
                    // Held eret leaves the handler now; its jump is parked
                    if (eret_ok && (hold || !pend_v))
                        state <= PCC_RUN;
                end
                default: state <= PCC_RUN;
            endcase
        end
    end

endmodule
